i2s_master_tx: RTL and testbench
================================

Name: i2s_master_tx

Overview:
- I2S bus master transmitter, single clock domain (Clk_Fast).
- Generates the bit clock (SCLK) by dividing Clk_Fast, and drives word-select (WS) and serial data (SD).
- Serialises stereo sample pairs accepted over a valid/ready handshake.
- Lets the DSP drive an external DAC or codec directly as bus master, with no CDC stage.

Parameters:
- WIDTH, 16, bits per channel word; must be ≥2.
- SCLK_DIV, 2, SCLK half-period in Clk_Fast cycles; must be ≥1. SCLK period = 2*SCLK_DIV.

Ports:
- Clk_Fast  in  1  system clock; all logic on posedge.
- Rst  in  1  asynchronous, active-high reset.
- Left_In  in  WIDTH  left sample, two's complement.
- Right_In  in  WIDTH  right sample.
- Sample_Valid  in  1  Left_In/Right_In pair is valid.
- Sample_Ready  out  1  holding register empty; pair accepted when Valid && Ready.
- Sclk_Out  out  1  I2S bit clock.
- Ws_Out  out  1  word select; 0 = left, 1 = right.
- Sd_Out  out  1  serial data, MSB first.
- Frame_Start  out  1  one-cycle pulse when a new frame loads into the shifter.
- Underrun  out  1  one-cycle pulse when a frame loads with the holding register empty.

Behaviour:
- Reset values (asynchronous): Sclk_Out=0, Ws_Out=1, Sd_Out=0, Sample_Ready=1, Frame_Start=0, Underrun=0.
  - Divider count=0, holding register empty/zero, shifter=0.
  - Bit pointer = (right, WIDTH-2).
- Divider:
  - Counter runs 0..SCLK_DIV-1; at terminal count it wraps and Sclk_Out toggles.
  - Rise tick = toggle 0→1. Fall tick = toggle 1→0.
  - First Sclk_Out rise occurs SCLK_DIV cycles after Rst deasserts.
- Fall-tick actions (all registered in the same Clk_Fast edge as the SCLK 1→0 toggle; SD/WS change on the SCLK falling edge, receiver samples on the rising edge):
  - Bit pointer advances. Index wraps WIDTH-1→0 and toggles the channel.
  - Ws_Out toggles when the new index == WIDTH-1, i.e. one bit before the next word's MSB (I2S standard).
  - Pointer (right,WIDTH-1)→(left,0) is a frame boundary:
    - The 2*WIDTH-bit shifter loads {holding_L, holding_R}.
    - Frame_Start pulses; the holding register is marked empty.
    - Sd_Out = left MSB.
  - Otherwise the shifter shifts left 1 and Sd_Out = the new MSB.
  - First frame after reset: first fall tick sets WS=0 and SD=0; second fall tick loads the frame.
- Handshake:
  - Sample_Ready = holding register empty.
  - An accept in cycle N sets Ready=0 at N+1.
  - Ready returns to 1 the cycle after a frame load.
- Underrun (holding empty at frame load):
  - Shifter loads zeros; Underrun pulses with Frame_Start.
  - An accept in the same cycle as an underrun load fills the holding register for the next frame only; it is never merged into the current frame.
- Sample_Valid held without an accept: data may change freely and is ignored.
- Rst mid-frame: all state returns to reset values immediately and any pending pair is discarded.

Optional Feature:
- Macro I2S_TX_HOLD_LAST_EN.
- Defined: on underrun, the shifter reloads the last successfully transmitted pair (all zeros if none since reset). Underrun still pulses.
- Undefined: on underrun, zeros are transmitted.

Decomposition:
- Shared package i2s_pkg:
  - typedef i2s_chan_e {CH_LEFT=0, CH_RIGHT=1}.
  - localparam I2S_DEFAULT_WIDTH=16.
  - Packed struct i2s_pos_t {chan, index}, also used by the existing receiver.
- Sub-module i2s_sclk_gen(Clk_Fast, Rst, Sclk_Out, Rise_Tick, Fall_Tick), parameterised by SCLK_DIV.
- Shifter, pointer and handshake logic stay in the top of this block.

Test Plan (WIDTH=16, SCLK_DIV=2 → SCLK period 4 cycles, frame 128 cycles):
- Reset release, no stimulus → Sclk_Out toggles every 2 cycles; Ws_Out falls at the first fall tick; first Frame_Start at the second fall tick with Underrun=1; SD=0 for the whole frame.
- Pair L=16'hA5C3, R=16'h8001 accepted before frame 1 → sampling SD on SCLK rises yields 1010010111000011 while WS=0, then 1000000000000001 while WS=1; Ws_Out toggles exactly one SCLK before each MSB.
- Sample_Valid held high with changing data → exactly one accept per frame; Ready low from accept until the cycle after Frame_Start; no pair lost or repeated.
- Valid asserted in the same cycle as an underrun load with L=16'h1234 → current frame transmits zeros (or the last pair with I2S_TX_HOLD_LAST_EN); 16'h1234 appears in the next frame.
- Rst asserted mid-right-word → outputs return to reset values in the same cycle; after release, the pair loaded before reset is not transmitted and the sequence restarts as in the first scenario.
- Loopback through the existing I2S receiver clocked by Sclk_Out → received left/right equal the transmitted pairs for 8 consecutive random frames.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding, bit-pointer type and the pointer
// advance rule used by both the transmitter and the receiver.
package i2s_pkg;

  localparam int I2S_DEFAULT_WIDTH = 16;
  // Index field width; covers channel words up to 256 bits.
  localparam int I2S_IDX_W = 8;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  typedef struct packed {
    i2s_chan_e              chan;
    logic [I2S_IDX_W-1:0]   index;
  } i2s_pos_t;

  // Step the bit pointer: index wraps WIDTH-1 -> 0 and flips the channel.
  function automatic i2s_pos_t pos_advance(i2s_pos_t pos, int unsigned width);
    i2s_pos_t nxt;
    nxt = pos;
    if (pos.index == I2S_IDX_W'(width - 1)) begin
      nxt.index = '0;
      nxt.chan  = (pos.chan == CH_LEFT) ? CH_RIGHT : CH_LEFT;
    end else begin
      nxt.index = pos.index + I2S_IDX_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/i2s_master_tx_if.sv
// Sample handshake and I2S bus signals of the master transmitter.
// master: the transmitter side; slave: the sample source / bus observer.
interface i2s_master_tx_if
  import i2s_pkg::*;
#(
  parameter int WIDTH = I2S_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] Left_In;
  logic [WIDTH-1:0] Right_In;
  logic             Sample_Valid;
  logic             Sample_Ready;
  logic             Sclk_Out;
  logic             Ws_Out;
  logic             Sd_Out;
  logic             Frame_Start;
  logic             Underrun;

  modport master (
    input  Left_In, Right_In, Sample_Valid,
    output Sample_Ready, Sclk_Out, Ws_Out, Sd_Out, Frame_Start, Underrun
  );

  modport slave (
    output Left_In, Right_In, Sample_Valid,
    input  Sample_Ready, Sclk_Out, Ws_Out, Sd_Out, Frame_Start, Underrun
  );

endinterface

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: Sclk_Out toggles every SCLK_DIV Clk_Fast cycles.
// Rise_Tick/Fall_Tick flag the cycle whose closing edge makes that toggle.
module i2s_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic Clk_Fast,
  input  logic Rst,
  output logic Sclk_Out,
  output logic Rise_Tick,
  output logic Fall_Tick
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_term;

  assign w_term = (r_cnt == CNT_LAST);

  // Count 0..SCLK_DIV-1, wrap and toggle the bit clock at terminal count.
  always_ff @(posedge Clk_Fast or posedge Rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (Rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_term) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign Sclk_Out  = r_sclk;
  assign Rise_Tick = w_term && !r_sclk;
  assign Fall_Tick = w_term &&  r_sclk;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S bus master transmitter: divides Clk_Fast into SCLK, drives WS and SD
// (MSB first, WS leading the MSB by one bit) from stereo pairs taken over a
// valid/ready handshake into a single holding register.
// Optional: define I2S_TX_HOLD_LAST_EN to resend the last transmitted pair
// on underrun instead of zeros.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH    = I2S_DEFAULT_WIDTH,
  parameter int SCLK_DIV = 2
) (
  input logic             Clk_Fast,
  input logic             Rst,
  i2s_master_tx_if.master bus
);

  localparam int FRAME_W = 2 * WIDTH;
  localparam logic [I2S_IDX_W-1:0] IDX_LAST = I2S_IDX_W'(WIDTH - 1);
  localparam i2s_pos_t POS_RESET = '{chan: CH_RIGHT, index: I2S_IDX_W'(WIDTH - 2)};

  logic               w_sclk;
  logic               w_rise_tick;
  logic               w_fall_tick;
  logic               w_load;
  logic               w_accept;
  i2s_pos_t           r_pos;
  i2s_pos_t           w_pos_next;
  logic               r_ws;
  logic               r_hold_full;
  logic [WIDTH-1:0]   r_hold_l;
  logic [WIDTH-1:0]   r_hold_r;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] w_load_word;
  logic               r_frame_start;
  logic               r_underrun;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [FRAME_W-1:0] r_last;
`endif

  i2s_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .Clk_Fast  (Clk_Fast),
    .Rst       (Rst),
    .Sclk_Out  (w_sclk),
    .Rise_Tick (w_rise_tick),
    .Fall_Tick (w_fall_tick)
  );

  assign w_pos_next = pos_advance(r_pos, WIDTH);
  // A frame loads on the fall tick that leaves the last right-channel bit.
  assign w_load     = w_fall_tick && (r_pos.chan == CH_RIGHT) && (r_pos.index == IDX_LAST);
  assign w_accept   = bus.Sample_Valid && !r_hold_full;

  // Select the word the shifter takes at a frame boundary.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_load_word = {r_hold_l, r_hold_r};
    if (!r_hold_full) begin
`ifdef I2S_TX_HOLD_LAST_EN
      w_load_word = r_last;
`else
      w_load_word = '0;
`endif
    end
  end

  // Bit pointer and word select advance on SCLK fall ticks.
  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst) begin
      r_pos <= POS_RESET;
      r_ws  <= 1'b1;
    end else if (w_fall_tick) begin
      r_pos <= w_pos_next;
      if (w_pos_next.index == IDX_LAST) r_ws <= ~r_ws;
    end
  end

  // Shifter: load a frame at the boundary, otherwise shift towards the MSB.
  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst) begin
      r_shift <= '0;
    end else if (w_fall_tick) begin
      if (w_load) r_shift <= w_load_word;
      else        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
    end
  end

  // Holding register: filled by an accept, emptied by a frame load.
  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_l    <= bus.Left_In;
      r_hold_r    <= bus.Right_In;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Frame-start and underrun pulses, aligned with the left MSB on SD.
  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_hold_full;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  // Remember the last pair actually taken from the holding register.
  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst)                     r_last <= '0;
    else if (w_load && r_hold_full) r_last <= {r_hold_l, r_hold_r};
  end
`endif

  // Ticks mark edges of the divided clock from its current level.
  assert property (@(posedge Clk_Fast) disable iff (Rst) w_rise_tick |-> !w_sclk);
  assert property (@(posedge Clk_Fast) disable iff (Rst) w_fall_tick |->  w_sclk);

  assign bus.Sclk_Out     = w_sclk;
  assign bus.Ws_Out       = r_ws;
  assign bus.Sd_Out       = r_shift[FRAME_W-1];
  assign bus.Sample_Ready = !r_hold_full;
  assign bus.Frame_Start  = r_frame_start;
  assign bus.Underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Self-checking bench for i2s_master_tx (WIDTH=16, SCLK_DIV=2).
// Expected bus values come from frame/bit arithmetic on the cycle count since
// reset release plus a holding-register model; a bench-side I2S receiver
// reassembles sample pairs from SD/WS at SCLK rises.
module tb_i2s_master_tx;

  localparam int W   = 16;
  localparam int DIV = 2;
  localparam int FW  = 2 * W;
  localparam int TP  = 2 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2s_master_tx_if #(.WIDTH(W)) bus ();

  i2s_master_tx #(.WIDTH(W), .SCLK_DIV(DIV)) dut (
    .Clk_Fast (clk),
    .Rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    int   cyc;
    logic sclk, ws, sd, fs, ur, rdy;
  } vec_t;

  vec_t vecs [13];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state.
  logic          m_full;
  logic [FW-1:0] m_hold;
  logic [FW-1:0] m_last;
  logic [FW-1:0] frames [$];
  logic          under_q [$];
  logic [FW-1:0] acc_q [$];

  // Bench receiver state.
  logic          rx_prev_sclk;
  logic          rx_prev_ws;
  logic [W-1:0]  rx_sh;
  logic [W-1:0]  rx_left;
  logic          rx_have_left;
  logic [FW-1:0] rx_pairs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic is_load(int c);
    return (c > 0) && (c % TP == 0) && (c / TP >= 2) && (((c / TP) - 2) % FW == 0);
  endfunction

  function automatic logic exp_sclk(int c);
    return ((c / DIV) % 2) == 1;
  endfunction

  function automatic logic exp_ws(int c);
    int nf, b;
    nf = c / TP;
    if (nf == 0) return 1'b1;
    if (nf == 1) return 1'b0;
    b = (nf - 2) % FW;
    return (b >= W - 1) && (b < FW - 1);
  endfunction

  function automatic logic exp_sd(int c);
    int nf, b, fr;
    logic [FW-1:0] word;
    nf = c / TP;
    if (nf < 2) return 1'b0;
    fr = (nf - 2) / FW;
    b  = (nf - 2) % FW;
    if (fr >= frames.size()) return 1'bx;
    word = frames[fr];
    return word[FW-1-b];
  endfunction

  function automatic logic exp_ur(int c);
    if (!is_load(c) || under_q.size() == 0) return 1'b0;
    return under_q[under_q.size()-1];
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_full = 1'b0;
    m_hold = '0;
    m_last = '0;
    frames.delete();
    under_q.delete();
    acc_q.delete();
    rx_prev_sclk = 1'b0;
    rx_prev_ws   = 1'b1;
    rx_sh        = '0;
    rx_left      = '0;
    rx_have_left = 1'b0;
    rx_pairs.delete();
  endtask

  // Model of one Clk_Fast edge: frame load first, then the handshake.
  task automatic model_edge();
    logic ld;
    cyc++;
    ld = is_load(cyc);
    if (ld) begin
      if (m_full) begin
        frames.push_back(m_hold);
        m_last = m_hold;
        under_q.push_back(1'b0);
      end else begin
`ifdef I2S_TX_HOLD_LAST_EN
        frames.push_back(m_last);
`else
        frames.push_back('0);
`endif
        under_q.push_back(1'b1);
      end
    end
    if (bus.Sample_Valid && !m_full) begin
      m_hold = {bus.Left_In, bus.Right_In};
      m_full = 1'b1;
      acc_q.push_back(m_hold);
    end else if (ld) begin
      m_full = 1'b0;
    end
  endtask

  task automatic rx_sample();
    logic sclk, ws, sd;
    sclk = bus.Sclk_Out;
    ws   = bus.Ws_Out;
    sd   = bus.Sd_Out;
    if (sclk && !rx_prev_sclk) begin
      rx_sh = {rx_sh[W-2:0], sd};
      if (ws != rx_prev_ws) begin
        if (rx_prev_ws == 1'b0) begin
          rx_left      = rx_sh;
          rx_have_left = 1'b1;
        end else if (rx_have_left) begin
          rx_pairs.push_back({rx_left, rx_sh});
          rx_have_left = 1'b0;
        end
      end
      rx_prev_ws = ws;
    end
    rx_prev_sclk = sclk;
  endtask

  // One clock: model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("sclk",  bus.Sclk_Out,     exp_sclk(cyc));
    check("ws",    bus.Ws_Out,       exp_ws(cyc));
    check("sd",    bus.Sd_Out,       exp_sd(cyc));
    check("ready", bus.Sample_Ready, !m_full);
    check("fs",    bus.Frame_Start,  is_load(cyc));
    check("ur",    bus.Underrun,     exp_ur(cyc));
    rx_sample();
  endtask

  // Assert reset mid-cycle, check outputs at once, release on a falling edge.
  task automatic do_reset();
    bus.Sample_Valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_sclk",  bus.Sclk_Out,     1'b0);
    check("rst_ws",    bus.Ws_Out,       1'b1);
    check("rst_sd",    bus.Sd_Out,       1'b0);
    check("rst_ready", bus.Sample_Ready, 1'b1);
    check("rst_fs",    bus.Frame_Start,  1'b0);
    check("rst_ur",    bus.Underrun,     1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_table();
    for (int i = 0; i < 13; i++) begin
      while (cyc < vecs[i].cyc) tick();
      check($sformatf("v%0d_sclk", i),  bus.Sclk_Out,     vecs[i].sclk);
      check($sformatf("v%0d_ws", i),    bus.Ws_Out,       vecs[i].ws);
      check($sformatf("v%0d_sd", i),    bus.Sd_Out,       vecs[i].sd);
      check($sformatf("v%0d_fs", i),    bus.Frame_Start,  vecs[i].fs);
      check($sformatf("v%0d_ur", i),    bus.Underrun,     vecs[i].ur);
      check($sformatf("v%0d_ready", i), bus.Sample_Ready, vecs[i].rdy);
    end
  endtask

  task automatic wait_pairs(input int n, input int budget);
    for (int i = 0; i < budget && rx_pairs.size() < n; i++) tick();
    check("rx_count", (rx_pairs.size() >= n), 1'b1);
  endtask

  function automatic logic [FW-1:0] rx_at(int i);
    if (i < rx_pairs.size()) return rx_pairs[i];
    return 'x;
  endfunction

  initial begin
    logic [FW-1:0] p0;
    logic [FW-1:0] exp_f1;

    //           cyc  sclk ws  sd  fs  ur  rdy
    vecs[0]  = '{0,   0,   1,  0,  0,  0,  1};
    vecs[1]  = '{1,   0,   1,  0,  0,  0,  1};
    vecs[2]  = '{2,   1,   1,  0,  0,  0,  1};
    vecs[3]  = '{3,   1,   1,  0,  0,  0,  1};
    vecs[4]  = '{4,   0,   0,  0,  0,  0,  1};
    vecs[5]  = '{6,   1,   0,  0,  0,  0,  1};
    vecs[6]  = '{7,   1,   0,  0,  0,  0,  1};
    vecs[7]  = '{8,   0,   0,  0,  1,  1,  1};
    vecs[8]  = '{9,   0,   0,  0,  0,  0,  1};
    vecs[9]  = '{64,  0,   0,  0,  0,  0,  1};
    vecs[10] = '{68,  0,   1,  0,  0,  0,  1};
    vecs[11] = '{132, 0,   0,  0,  0,  0,  1};
    vecs[12] = '{136, 0,   0,  0,  1,  1,  1};

    bus.Sample_Valid = 1'b0;
    bus.Left_In      = '0;
    bus.Right_In     = '0;

    // Reset release with no stimulus.
    do_reset();
    run_table();

    // Single directed pair ahead of the first frame.
    do_reset();
    bus.Left_In      = 16'hA5C3;
    bus.Right_In     = 16'h8001;
    bus.Sample_Valid = 1'b1;
    tick();
    bus.Sample_Valid = 1'b0;
    wait_pairs(1, 300);
    check("dir_left",  rx_at(0) >> W,     32'h0000A5C3);
    check("dir_right", rx_at(0) & 32'hFFFF, 32'h00008001);

    // Valid held high with changing data; loopback of 8 random frames.
    do_reset();
    for (int i = 0; i < 12 * TP * FW && rx_pairs.size() < 8; i++) begin
      bus.Left_In      = 16'($urandom);
      bus.Right_In     = 16'($urandom);
      bus.Sample_Valid = 1'b1;
      tick();
    end
    bus.Sample_Valid = 1'b0;
    check("loop_count", (rx_pairs.size() >= 8), 1'b1);
    for (int i = 0; i < 8; i++)
      check($sformatf("loop_pair%0d", i), rx_at(i), (i < acc_q.size()) ? acc_q[i] : 'x);

    // Accept in the same cycle as an underrun load.
    do_reset();
    p0 = $urandom;
    bus.Left_In      = p0[FW-1:W];
    bus.Right_In     = p0[W-1:0];
    bus.Sample_Valid = 1'b1;
    tick();
    bus.Sample_Valid = 1'b0;
    while (cyc < TP * (2 + FW) - 1) tick();
    bus.Left_In      = 16'h1234;
    bus.Right_In     = 16'($urandom);
    bus.Sample_Valid = 1'b1;
    tick();
    bus.Sample_Valid = 1'b0;
    check("ur_same_cycle", bus.Underrun, 1'b1);
    check("ur_ready_low",  bus.Sample_Ready, 1'b0);
    wait_pairs(3, 600);
`ifdef I2S_TX_HOLD_LAST_EN
    exp_f1 = p0;
`else
    exp_f1 = '0;
`endif
    check("ur_frame0", rx_at(0), p0);
    check("ur_frame1", rx_at(1), exp_f1);
    check("ur_frame2_left", rx_at(2) >> W, 32'h00001234);

    // Reset mid right word with a pair still pending in the holding register.
    do_reset();
    bus.Left_In      = 16'($urandom);
    bus.Right_In     = 16'($urandom);
    bus.Sample_Valid = 1'b1;
    tick();
    bus.Sample_Valid = 1'b0;
    while (cyc < 20) tick();
    bus.Left_In      = 16'($urandom);
    bus.Right_In     = 16'($urandom);
    bus.Sample_Valid = 1'b1;
    tick();
    bus.Sample_Valid = 1'b0;
    while (cyc < 100) tick();
    do_reset();
    run_table();
    wait_pairs(1, 200);
    check("post_rst_frame0", rx_at(0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
